// File: rtl/arbt_pkg.sv
// Shared arbiter definitions: policy selector, control-state encoding and index sizing.
package arbt_pkg;

  typedef enum logic [1:0] {
    ARBT_FP_LSB,
    ARBT_FP_MSB,
    ARBT_RR
  } arbt_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } arbt_state_e;

  // A single-bit index is kept even for degenerate widths so ports never collapse to zero bits.
  function automatic int arbt_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbt_rr_if.sv
// Request/grant bundle between N request sources, the arbiter and the single consumer.
interface arbt_rr_if
  import arbt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ARBT_WIDTH = 4
) ();

  localparam int IDX_WIDTH = arbt_idx_width(ARBT_WIDTH);

  logic [DATA_WIDTH-1:0] data_i [ARBT_WIDTH];
  logic [ARBT_WIDTH-1:0] req_i;
  logic [ARBT_WIDTH-1:0] gnt_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [IDX_WIDTH-1:0]  idx_o;
  logic                  rdy_o;
  logic                  ack_i;

  modport master (
    output data_i, req_i, ack_i,
    input  gnt_o, data_o, idx_o, rdy_o
  );

  modport slave (
    input  data_i, req_i, ack_i,
    output gnt_o, data_o, idx_o, rdy_o
  );

endinterface

// File: rtl/arbt_pick.sv
// Combinational circular priority selector: first set request at or after start,
// searching upward (or downward when MSB_FIRST) with wrap-around.
module arbt_pick #(
  parameter int WIDTH     = 4,
  parameter int IDX_W     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      int p;
      logic [IDX_W-1:0] pos;
      p = MSB_FIRST ? (int'(start) - k) : (int'(start) + k);
      if (p >= WIDTH) p = p - WIDTH;
      if (p < 0)      p = p + WIDTH;
      pos = IDX_W'(p);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/arbt_rr.sv
// N-way arbiter with fixed-priority or round-robin policy, registered single-entry
// output stage and back-to-back hand-off when the consumer acknowledges.
module arbt_rr
  import arbt_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ARBT_WIDTH = 4,
  parameter arbt_mode_e            ARBT_MODE  = ARBT_RR,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  arbt_rr_if.slave   bus
);

  localparam int IDX_WIDTH = arbt_idx_width(ARBT_WIDTH);

  generate
    if (ARBT_WIDTH < 2) begin : g_width_check
      $error("arbt_rr: ARBT_WIDTH must be at least 2");
    end
  endgenerate

  arbt_state_e           state_q, state_d;
  logic [ARBT_WIDTH-1:0] gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;

  logic                  pend_q;
  logic                  arb_en;
  logic [ARBT_WIDTH-1:0] eff_req;
  logic [IDX_WIDTH-1:0]  start;
  logic                  found;
  logic [IDX_WIDTH-1:0]  win;

  assign pend_q  = (state_q == ST_PEND);
  assign arb_en  = !pend_q || bus.ack_i;
  // A requester still sees its grant this cycle; its held level is not a fresh request.
  assign eff_req = bus.req_i & ~gnt_q;

  always_comb begin
    start = '0;
    if (ARBT_MODE == ARBT_RR)          start = ptr_q;
    else if (ARBT_MODE == ARBT_FP_MSB) start = IDX_WIDTH'(ARBT_WIDTH - 1);
  end

  arbt_pick #(
    .WIDTH     (ARBT_WIDTH),
    .IDX_W     (IDX_WIDTH),
    .MSB_FIRST (ARBT_MODE == ARBT_FP_MSB)
  ) u_pick (
    .req   (eff_req),
    .start (start),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    data_d  = data_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (arb_en) begin
      if (found) begin
        state_d    = ST_PEND;
        gnt_d[win] = 1'b1;
        data_d     = bus.data_i[win];
        idx_d      = win;
        // Explicit wrap so non-power-of-two widths rotate correctly.
        if (ARBT_MODE == ARBT_RR) begin
          ptr_d = (win == IDX_WIDTH'(ARBT_WIDTH - 1)) ? '0 : win + IDX_WIDTH'(1);
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Output stage: grant pulse, payload, index, pending flag and rotation pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      data_q  <= RESET_VAL;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt_o  = gnt_q;
  assign bus.data_o = data_q;
  assign bus.idx_o  = idx_q;
  assign bus.rdy_o  = pend_q;

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_q));

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pend_q && !bus.ack_i) |=> ($stable(data_q) && $stable(idx_q) && pend_q));

  a_gnt_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (gnt_q != '0) |-> gnt_q[idx_q]);

endmodule
